// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Shared constants for the MMIO interconnect: FSM encoding, data
//            width and the current SoC address map.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam int c_DATA_W = 32;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // UART TX/RX/LSR share one 4 KiB page; the UART decodes the low bits itself.
    localparam logic [31:0] c_UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] c_UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] c_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] c_CLINT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] c_DIV_BASE   = 32'h1000_1000;
    localparam logic [31:0] c_DIV_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] c_SPARE_BASE = 32'h1000_2000;
    localparam logic [31:0] c_SPARE_MASK = 32'hFFFF_F000;

    function automatic int cnt_width(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bus_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_mux_if
// Purpose  : CPU-side request/response and slave-side fan-out signals of the
//            MMIO interconnect. 'slave' is the interconnect's view, 'master'
//            is the view of the CPU plus peripherals driving it.
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_bus_mux_if #(
    parameter int NUM_SLAVES = 4
);
    import mmio_pkg::*;

    logic                           m_valid;
    logic [c_DATA_W-1:0]            m_addr;
    logic [c_DATA_W-1:0]            m_wdata;
    logic [3:0]                     m_wstrb;
    logic                           m_ready;
    logic [c_DATA_W-1:0]            m_rdata;
    logic                           m_fault;

    logic [NUM_SLAVES-1:0]          s_valid;
    logic [c_DATA_W-1:0]            s_addr;
    logic [c_DATA_W-1:0]            s_wdata;
    logic [3:0]                     s_wstrb;
    logic [NUM_SLAVES-1:0]          s_ready;
    logic [c_DATA_W*NUM_SLAVES-1:0] s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, m_fault, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_fault, s_valid, s_addr, s_wdata, s_wstrb
    );

endinterface
`default_nettype wire

// File: rtl/mmio_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : mmio_addr_decode
// Purpose  : Combinational base/mask window matcher; lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                        NUM_SLAVES = 4,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = '0,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = '0
) (
    input  logic [c_DATA_W-1:0]   i_addr,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_hit_any
);

    logic [NUM_SLAVES-1:0] w_hit;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
        assign w_hit[gi] = ((i_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32]);
    end

    // Isolate the lowest set bit of the hit vector.
    assign o_sel     = w_hit & (~w_hit + NUM_SLAVES'(1));
    assign o_hit_any = |w_hit;

endmodule
`default_nettype wire

// File: rtl/mmio_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bus_mux
// Purpose  : CPU-to-peripheral MMIO interconnect with window decode, per-access
//            timeout and access-fault reporting on a registered response.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_mux
    import mmio_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE     = {c_SPARE_BASE, c_DIV_BASE, c_CLINT_BASE, c_UART_BASE},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK     = {c_SPARE_MASK, c_DIV_MASK, c_CLINT_MASK, c_UART_MASK},
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter int                       UNMAPPED_FAULT = 1,
    parameter logic [c_DATA_W-1:0]      ERR_RDATA      = 32'h0
) (
    input  logic          clk,
    input  logic          reset,
    mmio_bus_mux_if.slave bus
);

    localparam int                 c_CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    logic [1:0]            r_state;
    logic [NUM_SLAVES-1:0] r_sel;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_DATA_W-1:0]   r_rdata;
    logic                  r_fault;

    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_hit_any;
    logic [c_DATA_W-1:0]   w_slave_rdata;
    logic                  w_sel_ready;
    logic                  w_timeout;

    mmio_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .i_addr    (bus.m_addr),
        .o_sel     (w_sel),
        .o_hit_any (w_hit_any)
    );

    // sel is one-hot, so a plain AND-OR picks the active slave's data.
    always_comb begin
        w_slave_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_slave_rdata = w_slave_rdata |
                            (bus.s_rdata[c_DATA_W*i +: c_DATA_W] & {c_DATA_W{r_sel[i]}});
        end
    end

    assign w_sel_ready = |(bus.s_ready & r_sel);
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

    // Valid drops combinationally on a CPU abort or a reset, not a cycle later.
    assign bus.s_valid = (r_state == c_ST_WAIT && bus.m_valid && !reset) ? r_sel : '0;
    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;
    assign bus.m_ready = (r_state == c_ST_RESP);
    assign bus.m_rdata = r_rdata;
    assign bus.m_fault = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.m_valid) begin
                        if (w_hit_any) begin
                            r_sel   <= w_sel;
                            r_cnt   <= '0;
                            r_state <= c_ST_WAIT;
                        end else begin
                            r_fault <= (UNMAPPED_FAULT != 0);
                            r_rdata <= (UNMAPPED_FAULT != 0) ? ERR_RDATA : '0;
                            r_state <= c_ST_RESP;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (!bus.m_valid) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_sel_ready) begin
                        r_rdata <= w_slave_rdata;
                        r_fault <= 1'b0;
                        r_state <= c_ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= ERR_RDATA;
                        r_fault <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_RESP: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bus_mux
// Purpose  : Self-checking bench for mmio_bus_mux against a transaction-level
//            reference model (window decode plus latency/fault arithmetic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_mux;

    localparam int            NS  = 4;
    localparam int            TMO = 8;
    localparam logic [31:0]   ERR = 32'hBAD0_BAD0;
    localparam logic [32*NS-1:0] TB_BASE = {32'h3000_0000, 32'h1100_0000, 32'h1000_0000, 32'h1100_0000};
    localparam logic [32*NS-1:0] TB_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFF00_0000};

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mmio_bus_mux_if #(.NUM_SLAVES(NS)) bus ();
    mmio_bus_mux_if #(.NUM_SLAVES(NS)) bus_nf ();

    mmio_bus_mux #(
        .NUM_SLAVES(NS), .SLAVE_BASE(TB_BASE), .SLAVE_MASK(TB_MASK),
        .TIMEOUT_CYCLES(TMO), .UNMAPPED_FAULT(1), .ERR_RDATA(ERR)
    ) u_dut (.clk(clk), .reset(reset), .bus(bus));

    mmio_bus_mux #(
        .NUM_SLAVES(NS), .SLAVE_BASE(TB_BASE), .SLAVE_MASK(TB_MASK),
        .TIMEOUT_CYCLES(TMO), .UNMAPPED_FAULT(0), .ERR_RDATA(ERR)
    ) u_dut_nf (.clk(clk), .reset(reset), .bus(bus_nf));

    always #5 clk = ~clk;

    // Reference: first window (lowest index) that contains the address, or -1.
    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & TB_MASK[32*i +: 32]) == TB_BASE[32*i +: 32]) return i;
        return -1;
    endfunction

    // Reference: edges from request to m_ready, data, fault, slave-valid cycles.
    task automatic model_expect(input logic [31:0] addr, input int delay, input logic [31:0] data,
                                output int edges, output logic [31:0] rdata, output logic fault,
                                output logic [3:0] sv_seen, output int sv_cycles);
        int idx;
        idx = model_decode(addr);
        if (idx < 0) begin
            edges = 1; rdata = ERR; fault = 1'b1; sv_seen = '0; sv_cycles = 0;
        end else begin
            sv_seen = 4'(1 << idx);
            if (delay >= 1 && delay <= TMO) begin
                edges = 1 + delay; rdata = data; fault = 1'b0; sv_cycles = delay;
            end else begin
                edges = 1 + TMO; rdata = ERR; fault = 1'b1; sv_cycles = TMO;
            end
        end
    endtask

    // Drives one CPU access; the slave model answers on its delay-th valid cycle.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int delay, input logic [31:0] data, input bit stray,
                              output int edges, output logic [31:0] rdata, output logic fault,
                              output logic [3:0] sv_seen, output int sv_cycles, output logic [67:0] pass_seen);
        int vcnt;
        int idx;
        idx = model_decode(addr);
        vcnt = 0; edges = -1; sv_seen = '0; sv_cycles = 0; pass_seen = '0; rdata = '0; fault = 1'bx;
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
        if (idx >= 0) bus.s_rdata[32*idx +: 32] = data;
        bus.s_ready = '0;
        bus.m_addr = addr; bus.m_wdata = wdata; bus.m_wstrb = wstrb; bus.m_valid = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (bus.m_ready) begin
                edges = e; rdata = bus.m_rdata; fault = bus.m_fault;
                break;
            end
            bus.s_ready = '0;
            if (bus.s_valid != '0) begin
                vcnt++; sv_cycles++; sv_seen |= bus.s_valid;
                pass_seen = {bus.s_addr, bus.s_wdata, bus.s_wstrb};
                if (vcnt == delay) bus.s_ready = bus.s_valid;
            end
            if (stray && e == 2 && !bus.s_valid[3]) bus.s_ready[3] = 1'b1;
        end
        bus.m_valid = 1'b0; bus.s_ready = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({bus.m_ready, bus.m_fault, bus.m_rdata} !== 34'h0) begin
            n_err++; $display("FAIL reset_resp got %b/%b/%h exp 0/0/0", bus.m_ready, bus.m_fault, bus.m_rdata); end
        n_vec++; if (bus.s_valid !== 4'b0) begin
            n_err++; $display("FAIL reset_svalid got %b exp 0000", bus.s_valid); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus.m_ready !== 1'b0) begin
            n_err++; $display("FAIL idle_mready got %b exp 0", bus.m_ready); end
    endtask

    task automatic test_read_slave1();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        run_access(32'h1000_0004, 32'h0, 4'b0000, 2, 32'hDEAD_BEEF, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (e !== 3) begin n_err++; $display("FAIL rd1_latency got %0d exp 3", e); end
        n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd1_rdata got %h exp deadbeef", rd); end
        n_vec++; if (f !== 1'b0) begin n_err++; $display("FAIL rd1_fault got %b exp 0", f); end
        n_vec++; if (sv !== 4'b0010) begin n_err++; $display("FAIL rd1_svalid got %b exp 0010", sv); end
        @(posedge clk); #1;
        n_vec++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL rd1_pulse got %b exp 0", bus.m_ready); end
        n_vec++; if (bus.m_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd1_hold got %h exp deadbeef", bus.m_rdata); end
    endtask

    task automatic test_write_slave0();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        run_access(32'h1180_0000, 32'h41, 4'b0001, 1, 32'h0, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (ps !== {32'h1180_0000, 32'h41, 4'b0001}) begin
            n_err++; $display("FAIL wr0_pass got %h exp %h", ps, {32'h1180_0000, 32'h41, 4'b0001}); end
        n_vec++; if (sv !== 4'b0001) begin n_err++; $display("FAIL wr0_svalid got %b exp 0001", sv); end
        n_vec++; if (e !== 2 || f !== 1'b0) begin n_err++; $display("FAIL wr0_resp got %0d/%b exp 2/0", e, f); end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        run_access(32'h2000_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (e !== 1) begin n_err++; $display("FAIL unm_latency got %0d exp 1", e); end
        n_vec++; if (f !== 1'b1 || rd !== ERR) begin n_err++; $display("FAIL unm_resp got %b/%h exp 1/%h", f, rd, ERR); end
        n_vec++; if (sv !== 4'b0) begin n_err++; $display("FAIL unm_svalid got %b exp 0000", sv); end
        @(posedge clk); #1;
        bus_nf.m_addr = 32'h2000_0000; bus_nf.m_wstrb = 4'b0; bus_nf.m_valid = 1'b1;
        #1;
        n_vec++; if (bus_nf.s_valid !== 4'b0) begin n_err++; $display("FAIL unm_nf_svalid got %b exp 0000", bus_nf.s_valid); end
        @(posedge clk); #1;
        n_vec++; if ({bus_nf.m_ready, bus_nf.m_fault, bus_nf.m_rdata} !== {2'b10, 32'h0}) begin
            n_err++; $display("FAIL unm_nf_resp got %b/%b/%h exp 1/0/0", bus_nf.m_ready, bus_nf.m_fault, bus_nf.m_rdata); end
        bus_nf.m_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        run_access(32'h3000_0010, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (sc !== TMO) begin n_err++; $display("FAIL tmo_valid_cycles got %0d exp %0d", sc, TMO); end
        n_vec++; if (e !== TMO + 1 || f !== 1'b1 || rd !== ERR) begin
            n_err++; $display("FAIL tmo_resp got %0d/%b/%h exp %0d/1/%h", e, f, rd, TMO + 1, ERR); end
        @(posedge clk); #1;
        run_access(32'h3000_0020, 32'h0, 4'b0000, TMO, 32'h1234_5678, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (f !== 1'b0 || rd !== 32'h1234_5678) begin
            n_err++; $display("FAIL tmo_edge_resp got %b/%h exp 0/12345678", f, rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_overlap_stray();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        run_access(32'h1100_0000, 32'h0, 4'b0000, 3, 32'hCAFE_0001, 1'b1, e, rd, f, sv, sc, ps);
        n_vec++; if (sv !== 4'b0001) begin n_err++; $display("FAIL ovl_svalid got %b exp 0001", sv); end
        n_vec++; if (e !== 4 || rd !== 32'hCAFE_0001) begin
            n_err++; $display("FAIL ovl_stray got %0d/%h exp 4/cafe0001", e, rd); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort_and_reset();
        int e, sc; logic [31:0] rd; logic f; logic [3:0] sv; logic [67:0] ps;
        logic seen;
        bus.s_ready = '0;
        bus.m_addr = 32'h1000_0008; bus.m_wstrb = 4'b0; bus.m_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.s_valid !== 4'b0010) begin n_err++; $display("FAIL abt_pre got %b exp 0010", bus.s_valid); end
        bus.m_valid = 1'b0;
        #1;
        n_vec++; if (bus.s_valid !== 4'b0) begin n_err++; $display("FAIL abt_svalid got %b exp 0000", bus.s_valid); end
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; seen |= bus.m_ready; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abt_no_ready got %b exp 0", seen); end
        // Reset while waiting on a slave.
        bus.m_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_vec++; if (bus.s_valid !== 4'b0) begin n_err++; $display("FAIL rst_svalid got %b exp 0000", bus.s_valid); end
        @(posedge clk); #1;
        n_vec++; if ({bus.m_ready, bus.m_fault, bus.m_rdata, bus.s_valid} !== 38'h0) begin
            n_err++; $display("FAIL rst_outputs got %b/%b/%h/%b exp all 0", bus.m_ready, bus.m_fault, bus.m_rdata, bus.s_valid); end
        reset = 1'b0; bus.m_valid = 1'b0;
        @(posedge clk); #1;
        run_access(32'h1000_0008, 32'h0, 4'b0000, 1, 32'h5555_AAAA, 1'b0, e, rd, f, sv, sc, ps);
        n_vec++; if (e !== 2 || rd !== 32'h5555_AAAA || f !== 1'b0) begin
            n_err++; $display("FAIL rst_recover got %0d/%h/%b exp 2/5555aaaa/0", e, rd, f); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int e, sc, xe, xsc, delay, pick;
        logic [31:0] rd, xrd, addr, data;
        logic f, xf;
        logic [3:0] sv, xsv;
        logic [67:0] ps;
        for (int n = 0; n < 30; n++) begin
            pick  = $urandom_range(0, NS);
            delay = $urandom_range(0, TMO + 2);
            data  = $urandom;
            if (pick == NS) addr = 32'h2000_0000 | ($urandom & 32'h00FF_FFFC);
            else addr = TB_BASE[32*pick +: 32] | ($urandom & ~TB_MASK[32*pick +: 32]);
            model_expect(addr, delay, data, xe, xrd, xf, xsv, xsc);
            run_access(addr, $urandom, 4'($urandom), delay, data, 1'($urandom), e, rd, f, sv, sc, ps);
            n_vec++; if (e !== xe) begin n_err++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, e, xe); end
            n_vec++; if (rd !== xrd || f !== xf) begin
                n_err++; $display("FAIL rnd%0d_resp got %h/%b exp %h/%b", n, rd, f, xrd, xf); end
            n_vec++; if (sv !== xsv || sc !== xsc) begin
                n_err++; $display("FAIL rnd%0d_svalid got %b/%0d exp %b/%0d", n, sv, sc, xsv, xsc); end
            @(posedge clk); #1;
            n_vec++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL rnd%0d_pulse got %b exp 0", n, bus.m_ready); end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; reset = 1'b1;
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.s_ready = '0; bus.s_rdata = '0;
        bus_nf.m_valid = 1'b0; bus_nf.m_addr = '0; bus_nf.m_wdata = '0; bus_nf.m_wstrb = '0;
        bus_nf.s_ready = '0; bus_nf.s_rdata = '0;
        test_reset();
        test_read_slave1();
        test_write_slave0();
        test_unmapped();
        test_timeout();
        test_overlap_stray();
        test_abort_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
